// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output stage.
//   PWM_BITS        : PWM counter / duty width
//   DUTY_FULL       : duty code that forces a constant-high waveform
//   DEFAULT_CLK_DIV : system clocks per PWM counter step (10 MHz -> ~3 kHz)
//   NUM_PINS        : number of driven output pins
package pwm_pkg;

  localparam int unsigned PWM_BITS        = 8;
  localparam logic [7:0]  DUTY_FULL       = 8'hFF;
  localparam int unsigned DEFAULT_CLK_DIV = 13;
  localparam int unsigned NUM_PINS        = 16;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV clocks.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset (counter restarts at 0)
//   tick  : high while the internal count sits at CLK_DIV-1
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned      CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             tick_next;

  // tick is registered from the next count so it always equals (cnt == LAST)
  always_comb begin
    cnt_next  = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    tick_next = (cnt_next == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= (LAST == '0);
    end else begin
      cnt  <= cnt_next;
      tick <= tick_next;
    end
  end

endmodule : pwm_prescaler

// File: rtl/pwm_output_stage.sv
// Shared 8-bit PWM generator with a double-buffered duty and a 16-pin
// registered output mux (forced low / static high / PWM per pin).
// Ports:
//   clk, rst_n           : system clock, synchronous active-low reset
//   en_reg_out_*         : per-pin output enable
//   en_reg_pwm_*         : per-pin PWM-mode select
//   pwm_duty_cycle       : requested duty in 1/256 steps (0xFF = always high)
//   out                  : registered pin drive
//   period_start         : one-cycle pulse when pwm_cnt first reads 0
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEFAULT_CLK_DIV,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [PWM_BITS-1:0] pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                period_start
);

  logic                started;
  logic                presc_rst_n;
  logic                tick;
  logic                period_wrap;
  logic                pwm_lvl;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_cnt_next;
  logic [PWM_BITS-1:0] duty_shadow;
  logic [PWM_BITS-1:0] duty_next;
  logic                period_start_next;
  logic [NUM_PINS-1:0] en_out;
  logic [NUM_PINS-1:0] en_pwm;
  logic [NUM_PINS-1:0] out_next;

  // Holding the prescaler through the first cycle after release makes that
  // cycle the first clock of a full-length period.
  assign presc_rst_n = rst_n & started;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (presc_rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Counter, duty shadow, period pulse and pin mux next-state
  always_comb begin
    pwm_cnt_next      = pwm_cnt;
    duty_next         = duty_shadow;
    period_start_next = 1'b0;

    period_wrap = tick && (pwm_cnt == '1);
    pwm_lvl     = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);

    if (!started) begin
      pwm_cnt_next      = '0;
      duty_next         = pwm_duty_cycle;
      period_start_next = 1'b1;
    end else begin
      if (tick) begin
        pwm_cnt_next = pwm_cnt + PWM_BITS'(1);
      end
      if (period_wrap) begin
        duty_next = pwm_duty_cycle;
      end
      period_start_next = period_wrap;
    end

    // disabled -> 0, enabled static -> 1, enabled PWM -> pwm_lvl
    out_next = en_out & (~en_pwm | {NUM_PINS{pwm_lvl}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started      <= 1'b0;
      pwm_cnt      <= '0;
      duty_shadow  <= '0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      started      <= 1'b1;
      pwm_cnt      <= pwm_cnt_next;
      duty_shadow  <= duty_next;
      period_start <= period_start_next;
      out          <= out_next;
    end
  end

endmodule : pwm_output_stage

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage. Expected per-period results for
// pin 8 (high-cycle count, rising edges) are queued when the duty is set up
// and popped when the period measured between period_start pulses ends.
module tb_pwm_output_stage;

  localparam int unsigned CLK_DIV = 13;
  localparam int          PERIOD  = 256 * CLK_DIV;

  typedef struct {
    int high;
    int rises;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_reg_out_7_0 = '0;
  logic [7:0]  en_reg_out_15_8 = '0;
  logic [7:0]  en_reg_pwm_7_0 = '0;
  logic [7:0]  en_reg_pwm_15_8 = '0;
  logic [7:0]  pwm_duty_cycle = '0;
  logic [15:0] out;
  logic        period_start;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pwm_output_stage #(
    .CLK_DIV  (CLK_DIV),
    .PWM_BITS (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int high, input int rises);
    exp_t e;
    e.high  = high;
    e.rises = rises;
    sb.push_back(e);
  endtask

  // Advance until period_start is seen, bounded by budget cycles.
  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < budget);
    chk(tag, 32'(period_start), 32'd1);
  endtask

  // Called at the negedge where period_start is high; measures one window up
  // to the next period_start. Optionally changes the duty at index chg_at.
  task automatic measure(input string tag, input logic [15:0] stat,
                         input int chg_at, input logic [7:0] chg_duty);
    exp_t e;
    int   high = 0;
    int   rises = 0;
    int   len = 0;
    int   bad = 0;
    logic prev = 1'b0;
    do begin
      if (len == chg_at) pwm_duty_cycle = chg_duty;
      if (out[8] === 1'b1) high++;
      if (len > 0 && prev === 1'b0 && out[8] === 1'b1) rises++;
      if ((out & 16'hFEFF) !== stat) bad++;
      prev = out[8];
      len++;
      @(negedge clk);
    end while (period_start !== 1'b1 && len < PERIOD + 100);
    e = sb.pop_front();
    chk({tag, "_len"},    32'(len),   32'(PERIOD));
    chk({tag, "_high"},   32'(high),  32'(e.high));
    chk({tag, "_rises"},  32'(rises), 32'(e.rises));
    chk({tag, "_static"}, 32'(bad),   32'd0);
  endtask

  initial begin
    // Reset with all inputs low
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_period_start", 32'(period_start), 32'd1);

    // Two idle periods: all pins low
    push_exp(0, 0);
    measure("idle_p0", 16'h0000, -1, 8'h00);
    push_exp(0, 0);
    measure("idle_p1", 16'h0000, -1, 8'h00);

    // Static-high pins 7..0, one clock latency
    en_reg_out_7_0 = 8'hFF;
    chk("static_before_edge", 32'(out), 32'h0);
    @(negedge clk);
    chk("static_latency", 32'(out), 32'h00FF);
    wait_start("static_wait_start", PERIOD + 10);

    // Pin 8 PWM; pin 9 PWM-selected but disabled; duty 0x80 from next period
    en_reg_out_15_8 = 8'h01;
    en_reg_pwm_15_8 = 8'h03;
    pwm_duty_cycle  = 8'h80;
    push_exp(0, 0);
    measure("duty00_pre", 16'h00FF, -1, 8'h00);
    push_exp(1664, 1);
    measure("duty80_p0", 16'h00FF, -1, 8'h00);

    // Duty 0x40 queued, then changed to 0xC0 at pwm_cnt = 100
    pwm_duty_cycle = 8'h40;
    push_exp(1664, 1);
    measure("duty80_p1", 16'h00FF, -1, 8'h00);
    push_exp(832, 1);
    measure("duty40_midchg", 16'h00FF, 100 * CLK_DIV, 8'hC0);

    // Duty 0x00 then 0xFF: constant low, then constant high across the wrap
    pwm_duty_cycle = 8'h00;
    push_exp(2496, 1);
    measure("dutyC0", 16'h00FF, -1, 8'h00);
    pwm_duty_cycle = 8'hFF;
    push_exp(0, 0);
    measure("duty00", 16'h00FF, -1, 8'h00);
    push_exp(3327, 1);
    measure("dutyFF_p0", 16'h00FF, -1, 8'h00);
    pwm_duty_cycle = 8'h80;
    push_exp(3328, 0);
    measure("dutyFF_p1", 16'h00FF, -1, 8'h00);

    // One-cycle reset at pwm_cnt = 200 aborts the period
    repeat (200 * CLK_DIV) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_out", 32'(out), 32'h0);
    chk("midreset_period_start", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_period_start", 32'(period_start), 32'd1);
    push_exp(1664, 1);
    measure("after_reset", 16'h00FF, -1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwm_output_stage
